// File: rtl/bird_sprite_draw_pkg.sv
// bird_sprite_draw_pkg: shared constants and side-band bundle type for the overlay pixel pipeline
package bird_sprite_draw_pkg;
  localparam int RGB_W = 12;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int SPRITE_W = 24;
  localparam int PIPE_LAT = 3;
  localparam logic [RGB_W-1:0] KEY_RGB = 12'h0F0;
  typedef struct packed {
    logic             in_box;
    logic             video_on;
    logic             hsync;
    logic             vsync;
    logic [RGB_W-1:0] bg_rgb;
    logic             pipe_px;
    logic             frame_end;
  } sband_t;
  // syncs idle high so a reset never emits a spurious sync pulse
  localparam sband_t SBAND_RST = '{in_box: 1'b0, video_on: 1'b0, hsync: 1'b1, vsync: 1'b1,
                                   bg_rgb: '0, pipe_px: 1'b0, frame_end: 1'b0};
endpackage

// File: rtl/bird_sprite_draw_sideband_delay.sv
// sideband_delay: N-stage shift register with a per-bit reset value for pipeline side-band bundles
module sideband_delay #(
  parameter int W = 1,
  parameter int N = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] sr_q [N];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) sr_q[i] <= RST_VAL;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < N; i++) sr_q[i] <= sr_q[i-1];
    end
  end
  assign q_o = sr_q[N-1];
endmodule

// File: rtl/bird_sprite_draw.sv
// bird_sprite_draw: addresses the bird ROM from the scan position and composites the keyed sprite over the background
module bird_sprite_draw #(
  parameter int          SPRITE_W   = bird_sprite_draw_pkg::SPRITE_W,
  parameter int          SCALE_LOG2 = 0,
  parameter logic [11:0] KEY_RGB    = bird_sprite_draw_pkg::KEY_RGB,
  parameter logic [9:0]  BIRD_X     = 10'd160
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  px_x,
  input  logic [9:0]  px_y,
  input  logic        video_on,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic [11:0] bg_rgb,
  input  logic        pipe_px,
  input  logic        frame_end,
  input  logic [9:0]  bird_y,
  input  logic        clear_hit,
  output logic [4:0]  rom_row,
  output logic [4:0]  rom_col,
  input  logic [11:0] rom_pixel,
  output logic [11:0] rgb,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        bird_hit
);
  import bird_sprite_draw_pkg::*;
  localparam int BOX = SPRITE_W << SCALE_LOG2;
  logic [9:0]  bird_y_q, bird_y_d;
  logic [10:0] dx, dy;
  logic        in_box, opaque, hit_now;
  logic [4:0]  rom_row_q, rom_row_d, rom_col_q, rom_col_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hsync_q, vsync_q, hit_acc_q, hit_acc_d, bird_hit_q, bird_hit_d;
  sband_t      sb_in, sb_d2;
  // bit 10 is the sign: anything left of / above the box is rejected rather than wrapped
  assign dx = {1'b0, px_x} - {1'b0, BIRD_X};
  assign dy = {1'b0, px_y} - {1'b0, bird_y_q};
  assign in_box = video_on & !dx[10] & !dy[10] & (dx[9:0] < 10'(BOX)) & (dy[9:0] < 10'(BOX));
  assign sb_in = '{in_box: in_box, video_on: video_on, hsync: hsync_i, vsync: vsync_i,
                   bg_rgb: bg_rgb, pipe_px: pipe_px, frame_end: frame_end};
  sideband_delay #(.W($bits(sband_t)), .N(2), .RST_VAL(SBAND_RST)) u_sb (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (sb_in),
    .q_o   (sb_d2)
  );
  always_comb begin
    bird_y_d   = frame_end ? bird_y : bird_y_q;
    rom_row_d  = in_box ? 5'(dy[9:0] >> SCALE_LOG2) : '0;
    rom_col_d  = in_box ? 5'(dx[9:0] >> SCALE_LOG2) : '0;
    opaque     = sb_d2.in_box & (rom_pixel != KEY_RGB);
    hit_now    = opaque & sb_d2.pipe_px & sb_d2.video_on;
    rgb_d      = !sb_d2.video_on ? '0 : (opaque ? rom_pixel : sb_d2.bg_rgb);
    hit_acc_d  = sb_d2.frame_end ? 1'b0 : (hit_acc_q | hit_now);
    bird_hit_d = (sb_d2.frame_end & (hit_acc_q | hit_now)) ? 1'b1 : (clear_hit ? 1'b0 : bird_hit_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bird_y_q   <= '0;
      rom_row_q  <= '0;
      rom_col_q  <= '0;
      rgb_q      <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      hit_acc_q  <= 1'b0;
      bird_hit_q <= 1'b0;
    end else begin
      bird_y_q   <= bird_y_d;
      rom_row_q  <= rom_row_d;
      rom_col_q  <= rom_col_d;
      rgb_q      <= rgb_d;
      hsync_q    <= sb_d2.hsync;
      vsync_q    <= sb_d2.vsync;
      hit_acc_q  <= hit_acc_d;
      bird_hit_q <= bird_hit_d;
    end
  end
  assign rom_row  = rom_row_q;
  assign rom_col  = rom_col_q;
  assign rgb      = rgb_q;
  assign hsync_o  = hsync_q;
  assign vsync_o  = vsync_q;
  assign bird_hit = bird_hit_q;
endmodule

// File: doc/bird_sprite_draw.md
Name: bird_sprite_draw

Overview:
- Pixel-pipeline stage directly upstream and downstream of the 24×24 bird sprite ROM.
- Converts the live VGA scan position and the bird's screen position into ROM row/col addresses.
- Absorbs the ROM's 1-cycle read latency, applies the colour-key transparency and composites the bird over the background RGB.
- Delays sync/blank to stay aligned, and latches a per-frame bird/pipe overlap flag for the game FSM.

Parameters:
- SPRITE_W, 24, sprite width/height in ROM texels (square sprite).
- SCALE_LOG2, 0, on-screen magnification 2^SCALE_LOG2 (0 = 1×, 1 = 2×).
- KEY_RGB, 12'h0F0, colour-key value treated as transparent.
- BIRD_X, 10'd160, fixed left edge of the bird box in screen pixels.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- px_x  in  10  current scan column
- px_y  in  10  current scan row
- video_on  in  1  active-area flag for px_x/px_y
- hsync_i  in  1  horizontal sync aligned with px_x
- vsync_i  in  1  vertical sync aligned with px_y
- bg_rgb  in  12  background/pipe colour for px_x/px_y
- pipe_px  in  1  1 = bg_rgb is a pipe pixel
- frame_end  in  1  one-cycle pulse on the last active pixel of a frame
- bird_y  in  10  top edge of the bird box; sampled only on frame_end
- clear_hit  in  1  clears bird_hit
- rom_row  out  5  ROM row address
- rom_col  out  5  ROM column address
- rom_pixel  in  12  ROM data, valid 1 cycle after rom_row/rom_col
- rgb  out  12  composited pixel
- hsync_o  out  1  hsync delayed to align with rgb
- vsync_o  out  1  vsync delayed to align with rgb
- bird_hit  out  1  sticky collision flag

Behaviour:
- Reset (async, rst_n=0): all pipeline registers, rgb=0, rom_row=0, rom_col=0, bird_hit=0, hit_acc=0, hsync_o=1, vsync_o=1 (idle-high syncs). bird_y_q is 0 after reset.
- Box size is BOX=SPRITE_W<<SCALE_LOG2.
- bird_y_q is a register loaded from bird_y on frame_end only, so the bird never tears mid-frame.
- S0 (combinational on inputs):
  - dx=px_x-BIRD_X and dy=px_y-bird_y_q, both 11-bit signed.
  - in_box = video_on & 0<=dx<BOX & 0<=dy<BOX.
  - A negative dx/dy or an underflow must never alias into the box.
- S1 (registered):
  - rom_row <= in_box ? dy>>SCALE_LOG2 : 0.
  - rom_col <= in_box ? dx>>SCALE_LOG2 : 0.
  - Delay in_box, video_on, hsync, vsync, bg_rgb, pipe_px and frame_end by one stage.
- S2 (registered): delay the same side-band signals again. rom_pixel is valid this cycle.
- Output register (S3):
  - opaque = in_box_d2 & (rom_pixel != KEY_RGB).
  - rgb <= !video_on_d2 ? 0 : (opaque ? rom_pixel : bg_rgb_d2).
  - hsync_o/vsync_o <= the S2 copies.
- Total latency is 3 clk, input to rgb/hsync_o/vsync_o, for every pixel, whether inside or outside the box.
- Collision accumulator (evaluated at S2):
  - hit_now = opaque & pipe_px_d2 & video_on_d2.
  - hit_acc <= (frame_end_d2 ? 0 : hit_acc) | (hit_now & !frame_end_d2).
  - On frame_end_d2: bird_hit <= bird_hit | hit_acc | hit_now.
- bird_hit is sticky until clear_hit. If clear_hit and a frame_end_d2 set land on the same cycle, the set wins.
- A frame_end with no overlap in that frame leaves bird_hit unchanged.
- Boxes partly off-screen (bird_y near 0 or near 480) draw clipped with no wrap-around.
- Reset mid-line: outputs go to reset values immediately. The pipeline refills within 3 cycles of reset release and needs no resync.

Decomposition:
- Shared package holds: RGB_W=12, screen constants (H_ACTIVE=640, V_ACTIVE=480), KEY_RGB, SPRITE_W, and the pixel-pipeline latency constant PIPE_LAT=3 for other overlay stages.
- One natural sub-module, sideband_delay: a parameterised N-stage shift register for the sync/blank/bg/pipe/frame_end bundle. It is reused by other overlay stages.
- The ROM itself stays external.

Test Plan:
- bird_y=100 loaded via frame_end; px_x=160, px_y=100, video_on=1 → rom_row=0, rom_col=0 one cycle later. With rom_pixel=12'hF00 one cycle after that, rgb=12'hF00 at cycle 3.
- px_x=183, px_y=123 → rom_row=23, rom_col=23. px_x=184 or px_x=159 → rgb=bg_rgb after 3 cycles, i.e. outside the box.
- rom_pixel=KEY_RGB inside the box with bg_rgb=12'h08F → rgb=12'h08F. Also check video_on=0 anywhere → rgb=0.
- SCALE_LOG2=1: px_x=160..161 → rom_col=0; px_x=206..207 → rom_col=23; px_x=208 → outside the box.
- Opaque bird pixel with pipe_px=1 mid-frame → bird_hit=1 exactly 1 cycle after frame_end_d2. The next frame with no overlap keeps bird_hit=1. clear_hit → 0. clear_hit on the same cycle as a set → 1.
- Change bird_y mid-frame → no effect until the next frame_end. Assert rst_n=0 mid-line → rgb=0 and hsync_o=vsync_o=1 immediately. Check hsync_o equals hsync_i delayed by exactly 3 cycles across a full line.
